// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding, mode constants and word-count helper for the PE scheduler
//   words_of(mode) : operand word count N = 256 >> mode
package mm_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  localparam logic [1:0] MODE_4096 = 2'b00;
  localparam logic [1:0] MODE_2048 = 2'b01;
  localparam logic [1:0] MODE_1024 = 2'b10;
  localparam logic [1:0] MODE_512  = 2'b11;
  localparam int NUM_PIPELINE_DEF = 12;
  function automatic logic [8:0] words_of(input logic [1:0] m);
    return 9'd256 >> m;
  endfunction
endpackage

// File: rtl/mm_word_cnt.sv
// mm_word_cnt: clear/enable counter that wraps to zero after reaching its terminal value
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear (wins over en)
//   en        : advance one step
//   last      : terminal value; an enabled step at last returns to zero
//   cnt       : current count
module mm_word_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : (cnt_q == last) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/mm_pe_sched.sv
// mm_pe_sched: sequences X-word loads, Y/M-word streams and pipeline drain for the Montgomery PE chain
//   clk, rstn          : clock, async active-low reset
//   req, abort, mode   : request (level), cancel, operand size (00=4096 .. 11=512 bit)
//   gnt, busy, done    : accept pulse, operation in flight, completion pulse
//   pe_start, pe_mode  : chain start level and latched mode
//   x_rd/x_addr/x_last : outer-loop X word read
//   ym_rd/ym_addr/ym_last : inner-loop Y/M word read
module mm_pe_sched
  import mm_pkg::*;
#(
  parameter int NUM_PIPELINE = NUM_PIPELINE_DEF,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              gnt,
  output logic              busy,
  output logic              pe_start,
  output logic [1:0]        pe_mode,
  output logic              x_rd,
  output logic [ADDR_W-1:0] x_addr,
  output logic              x_last,
  output logic              ym_rd,
  output logic [ADDR_W-1:0] ym_addr,
  output logic              ym_last,
  output logic              done
);
  localparam int DW = $clog2(NUM_PIPELINE + 1);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [ADDR_W-1:0] i_cnt, j_cnt, last;
  logic [DW-1:0] d_cnt;
  logic accept, clr, i_en, j_en, d_en, i_tc, j_tc, d_tc;
  assign last   = ADDR_W'(words_of(mode_q) - 9'd1);
  assign i_tc   = i_cnt == last;
  assign j_tc   = j_cnt == last;
  assign d_tc   = d_cnt == DW'(NUM_PIPELINE - 1);
  assign accept = state_q == ST_IDLE && req && !abort;
  assign clr    = state_q == ST_IDLE || abort;
  assign j_en   = state_q == ST_RUN;
  // i holds at N-1 on the final row so it never wraps; IDLE clears it
  assign i_en   = j_en && j_tc && !i_tc;
  assign d_en   = state_q == ST_DRAIN;
  mm_word_cnt #(.W(ADDR_W)) u_i (.clk(clk), .rstn(rstn), .clr(clr), .en(i_en), .last(last), .cnt(i_cnt));
  mm_word_cnt #(.W(ADDR_W)) u_j (.clk(clk), .rstn(rstn), .clr(clr), .en(j_en), .last(last), .cnt(j_cnt));
  mm_word_cnt #(.W(DW)) u_d (.clk(clk), .rstn(rstn), .clr(clr), .en(d_en), .last(DW'(NUM_PIPELINE - 1)), .cnt(d_cnt));
  always_comb begin
    state_d = state_q;
    mode_d  = accept ? mode : mode_q;
    case (state_q)
      ST_IDLE:  state_d = accept ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN:   state_d = !j_tc ? ST_RUN : i_tc ? ST_DRAIN : ST_LOAD;
      ST_DRAIN: state_d = d_tc ? ST_DONE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  assign busy     = state_q != ST_IDLE;
  assign pe_start = state_q inside {ST_LOAD, ST_RUN, ST_DRAIN};
  assign pe_mode  = mode_q;
  assign x_rd     = state_q == ST_LOAD;
  assign x_addr   = x_rd ? i_cnt : '0;
  assign x_last   = x_rd && i_tc;
  assign gnt      = x_rd && i_cnt == '0;
  assign ym_rd    = state_q == ST_RUN;
  assign ym_addr  = ym_rd ? j_cnt : '0;
  assign ym_last  = ym_rd && j_tc;
  assign done     = state_q == ST_DONE;
endmodule

// File: tb/tb_mm_pe_sched.sv
// tb_mm_pe_sched: directed self-checking bench for mm_pe_sched
module tb_mm_pe_sched;
  logic clk = 1'b0, rstn = 1'b0, req = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic gnt, busy, pe_start, x_rd, x_last, ym_rd, ym_last, done;
  logic [1:0] pe_mode;
  logic [7:0] x_addr, ym_addr;
  logic [25:0] outs;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [1:0] m;
    int n;
    int lat;
  } vec_t;
  vec_t tv[3];
  always #5 clk = ~clk;
  mm_pe_sched #(.NUM_PIPELINE(12), .ADDR_W(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .abort(abort), .mode(mode),
    .gnt(gnt), .busy(busy), .pe_start(pe_start), .pe_mode(pe_mode),
    .x_rd(x_rd), .x_addr(x_addr), .x_last(x_last),
    .ym_rd(ym_rd), .ym_addr(ym_addr), .ym_last(ym_last), .done(done)
  );
  assign outs = {gnt, busy, pe_start, pe_mode, x_rd, x_addr, x_last, ym_rd, ym_addr, ym_last, done};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int done_at, nx, ny, nxl, nyl, bad, ei, ej;
    done_at = -1; nx = 0; ny = 0; nxl = 0; nyl = 0; bad = 0; ei = 0; ej = 0;
    @(negedge clk);
    mode = v.m;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    mode = ~v.m;
    chk($sformatf("grant_m%0d", v.m), int'({gnt, busy, pe_start, x_rd, x_addr}), 'hf00);
    for (int c = 0; c <= v.lat + 4; c++) begin
      if (c > 0) @(negedge clk);
      if (x_rd && ym_rd) bad++;
      if (gnt && c > 0) bad++;
      if (pe_mode != v.m) bad++;
      if (x_rd) begin
        nx++;
        if (int'(x_addr) != ei) bad++;
        if (x_last != (ei == v.n - 1)) bad++;
        if (x_last) nxl++;
        ei++;
        ej = 0;
      end
      if (ym_rd) begin
        ny++;
        if (int'(ym_addr) != ej) bad++;
        if (ym_last != (ej == v.n - 1)) bad++;
        if (ym_last) nyl++;
        ej++;
      end
      if (done) begin
        done_at = c;
        break;
      end
    end
    chk($sformatf("done_latency_m%0d", v.m), done_at, v.lat);
    chk($sformatf("x_rd_count_m%0d", v.m), nx, v.n);
    chk($sformatf("ym_rd_count_m%0d", v.m), ny, v.n * v.n);
    chk($sformatf("x_last_count_m%0d", v.m), nxl, 1);
    chk($sformatf("ym_last_count_m%0d", v.m), nyl, v.n);
    chk($sformatf("stream_errors_m%0d", v.m), bad, 0);
    @(negedge clk);
    chk($sformatf("busy_after_done_m%0d", v.m), int'({busy, done, pe_start}), 0);
  endtask

  initial begin
    int bad, found, cur_i, done_at;
    tv[0] = '{m: 2'b11, n: 32,  lat: 1068};
    tv[1] = '{m: 2'b10, n: 64,  lat: 4172};
    tv[2] = '{m: 2'b01, n: 128, lat: 16524};
    #12;
    chk("reset_outs", int'(outs), 0);
    @(negedge clk);
    rstn = 1'b1;
    req = 1'b1;
    abort = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (outs != '0) bad++;
    end
    chk("req_abort_idle", bad, 0);
    req = 1'b0;
    abort = 1'b0;
    foreach (tv[k]) run_op(tv[k]);
    // asynchronous reset in the middle of row i=5
    @(negedge clk);
    mode = 2'b11;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    found = 0;
    for (int c = 0; c < 400 && found == 0; c++) begin
      if (x_rd && x_addr == 8'd5) found = 1;
      else @(negedge clk);
    end
    chk("reach_i5", found, 1);
    repeat (3) @(negedge clk);
    chk("mid_run_pe_start", int'({pe_start, ym_rd}), 3);
    #2 rstn = 1'b0;
    #1 chk("async_reset_outs", int'(outs), 0);
    @(negedge clk);
    rstn = 1'b1;
    req = 1'b1;
    mode = 2'b11;
    @(negedge clk);
    req = 1'b0;
    chk("restart_after_reset", int'({gnt, x_rd, x_addr}), 'h300);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_from_load", int'({busy, pe_start}), 0);
    // abort in RUN at i=3, j=10
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    found = 0;
    cur_i = -1;
    for (int c = 0; c < 400 && found == 0; c++) begin
      if (x_rd) cur_i = int'(x_addr);
      if (ym_rd && cur_i == 3 && ym_addr == 8'd10) found = 1;
      else @(negedge clk);
    end
    chk("reach_i3_j10", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_run_idle", int'({busy, pe_start, x_rd, ym_rd, done, gnt}), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("abort_no_done", bad, 0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("restart_after_abort", int'({gnt, x_rd, x_addr}), 'h300);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    // back-to-back with req held and a mode change during the first operation
    @(negedge clk);
    mode = 2'b11;
    req = 1'b1;
    @(negedge clk);
    mode = 2'b10;
    chk("b2b_gnt1", int'({gnt, pe_mode}), 'h7);
    done_at = -1;
    for (int c = 0; c < 1100; c++) begin
      if (done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_first_latency", done_at, 1068);
    chk("b2b_done_cycle", int'({busy, pe_start}), 'h2);
    @(negedge clk);
    chk("b2b_idle_gap", int'({gnt, busy, pe_start, done}), 0);
    @(negedge clk);
    chk("b2b_gnt2", int'({gnt, busy, pe_start, x_rd, x_addr}), 'hf00);
    chk("b2b_new_mode", int'(pe_mode), 2);
    req = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("final_idle", int'({busy, pe_start}), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
